// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dmem_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              zero_ext,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;

    always_comb begin
        byte_pos   = {offset, 3'b000};
        half_pos   = {offset[1], 4'b0000};
        byte_v     = word[byte_pos +: 8];
        half_v     = word[half_pos +: 16];
        load_data  = word;
        merge_data = word;
        unique case (size)
            SZ_BYTE: begin
                load_data = {{24{~zero_ext & byte_v[7]}}, byte_v};
                merge_data[byte_pos +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~zero_ext & half_v[15]}}, half_v};
                merge_data[half_pos +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: turns CPU byte/half/word requests into word memory commands.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_out,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t state, state_nx;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       wbuf;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              accept;
    logic              illegal;

    // Upper-address test by shift keeps it valid for any ADDR_W.
    assign illegal = (cpu_size == 2'b11)
                   | ((cpu_size == SZ_HALF) & cpu_addr[0])
                   | ((cpu_size == SZ_WORD) & (|cpu_addr[1:0]))
                   | ((cpu_addr >> ADDR_W) != 32'd0);

    assign accept = cpu_req & (state == S_IDLE);

    lsu_align u_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .zero_ext   (uns_q),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        cpu_ready      = 1'b0;
        cpu_done       = 1'b0;
        cpu_err        = 1'b0;
        mem_enable     = 1'b0;
        mem_read_write = 1'b0;
        unique case (state)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    if (illegal)
                        state_nx = S_RESP;
                    else if (cpu_we && cpu_size == SZ_WORD)
                        state_nx = S_WR;
                    else
                        state_nx = S_RD;
                end
            end
            S_RD: begin
                mem_enable = 1'b1;
                state_nx   = S_RD_WAIT;
            end
            S_RD_WAIT: state_nx = we_q ? S_WR : S_RESP;
            S_WR: begin
                mem_enable     = 1'b1;
                mem_read_write = 1'b1;
                state_nx       = S_RESP;
            end
            S_RESP: begin
                cpu_done = 1'b1;
                cpu_err  = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem_address  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_data_out = wbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wbuf      <= '0;
            cpu_rdata <= '0;
        end else begin
            if (accept) begin
                we_q    <= cpu_we;
                size_q  <= cpu_size;
                uns_q   <= cpu_unsigned;
                addr_q  <= cpu_addr[ADDR_W-1:0];
                wdata_q <= cpu_wdata;
                err_q   <= illegal;
                if (cpu_we && cpu_size == SZ_WORD)
                    wbuf <= cpu_wdata;
            end
            if (state == S_RD_WAIT) begin
                if (we_q) wbuf      <= merge_data;
                else      cpu_rdata <= load_data;
            end
        end
    end

endmodule
